// File: rtl/mcash_rtn_queue.sv
// mcash_rtn_queue: per-channel return-path queue for mcash.
// Buffers read-return beats from the shared cache pipeline and presents them
// on one channel's valid/ready return interface. A slot is reserved when the
// front-end accepts a request, so every return is guaranteed storage and the
// pipeline never has to stall or drop a beat.
module mcash_rtn_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      rsv_i,
  output logic                      credit_o,
  input  logic                      push_valid_i,
  input  logic [DW-1:0]             push_data_i,
  output logic                      rtn_valid_o,
  input  logic                      rtn_ready_i,
  output logic [DW-1:0]             rtn_data_o,
  output logic [$clog2(DEPTH):0]    occ_o,
  output logic                      err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] occ, rsv, free;
  logic          err;

  logic rsv_acc, push_acc, pop;
  logic rsv_bad, push_bad;

  // Free slots: neither holding data nor promised to an outstanding request.
  // Uses registered state only, so a pop this cycle never creates credit.
  always_comb begin
    free     = DEPTH_C - occ - rsv;
    credit_o = (free != '0);
  end

  // Accept/reject decisions for this cycle's reserve, push and pop.
  always_comb begin
    rsv_acc  = rsv_i & credit_o;
    rsv_bad  = rsv_i & ~credit_o;
    // A reservation granted this same cycle does not cover this push.
    push_acc = push_valid_i & (rsv != '0);
    push_bad = push_valid_i & (rsv == '0);
    pop      = rtn_valid_o & rtn_ready_i;
  end

  // Return-side outputs; data is forced to zero while the queue is empty.
  always_comb begin
    rtn_valid_o = (occ != '0);
    rtn_data_o  = rtn_valid_o ? mem[rd_ptr] : '0;
    occ_o       = occ;
    err_o       = err;
  end

  // Storage write; contents are deliberately not reset, validity lives in occ.
  always_ff @(posedge clk_i) begin
    if (push_acc) mem[wr_ptr] <= push_data_i;
  end

  // Pointers, counters and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rsv    <= '0;
      err    <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + AW'(1);
      if (pop)      rd_ptr <= rd_ptr + AW'(1);
      occ <= occ + CW'(push_acc) - CW'(pop);
      rsv <= rsv + CW'(rsv_acc) - CW'(push_acc);
      if (rsv_bad | push_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcash_rtn_queue.sv
// Directed self-checking bench for mcash_rtn_queue (DEPTH=4, DW=128).
// Inputs change 1ns after each rising edge; outputs are checked at that
// point, where they reflect only registered state.
module tb_mcash_rtn_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          rsv_i;
  logic          credit_o;
  logic          push_valid_i;
  logic [DW-1:0] push_data_i;
  logic          rtn_valid_o;
  logic          rtn_ready_i;
  logic [DW-1:0] rtn_data_o;
  logic [2:0]    occ_o;
  logic          err_o;

  int n_asrt = 0;
  int n_fail = 0;

  mcash_rtn_queue #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rsv_i        (rsv_i),
    .credit_o     (credit_o),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .rtn_valid_o  (rtn_valid_o),
    .rtn_ready_i  (rtn_ready_i),
    .rtn_data_o   (rtn_data_o),
    .occ_o        (occ_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rsv_i = 1'b0;
    push_valid_i = 1'b0;
    push_data_i = '0;
    rtn_ready_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // 1: reset state, then one idle cycle
    chk("rst_valid",  rtn_valid_o, 0);
    chk("rst_credit", credit_o,    1);
    chk("rst_occ",    occ_o,       0);
    chk("rst_err",    err_o,       0);
    chk("rst_data",   rtn_data_o,  0);
    tick();
    chk("idle_valid", rtn_valid_o, 0);
    chk("idle_occ",   occ_o,       0);

    // 2: reserve, idle, push A5 with ready high -> one-cycle return
    rsv_i = 1'b1;
    tick();
    rsv_i = 1'b0;
    chk("t2_credit", credit_o, 1);
    chk("t2_valid0", rtn_valid_o, 0);
    tick();
    push_valid_i = 1'b1;
    push_data_i  = 128'hA5;
    rtn_ready_i  = 1'b1;
    chk("t2_nobypass", rtn_valid_o, 0);
    tick();
    push_valid_i = 1'b0;
    chk("t2_valid", rtn_valid_o, 1);
    chk("t2_data",  rtn_data_o,  128'hA5);
    chk("t2_occ1",  occ_o,       1);
    tick();
    chk("t2_valid_drop", rtn_valid_o, 0);
    chk("t2_occ0",       occ_o,       0);
    chk("t2_data0",      rtn_data_o,  0);
    chk("t2_err",        err_o,       0);

    // 3: fill reservations, over-reserve, fill data, then drain in order
    rtn_ready_i = 1'b0;
    rsv_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t3_credit_%0d", i), credit_o, (i < 4) ? 1 : 0);
    end
    chk("t3_err_before", err_o, 0);
    tick();
    rsv_i = 1'b0;
    chk("t3_err_over", err_o, 1);
    chk("t3_credit_over", credit_o, 0);
    for (int i = 1; i <= 4; i++) begin
      push_valid_i = 1'b1;
      push_data_i  = DW'(i);
      tick();
    end
    push_valid_i = 1'b0;
    chk("t3_occ4",   occ_o,      4);
    chk("t3_head",   rtn_data_o, 1);
    chk("t3_credit", credit_o,   0);
    tick();
    chk("t3_hold_valid", rtn_valid_o, 1);
    chk("t3_hold_data",  rtn_data_o,  1);
    // a 5th push finds rsv==0 after four covered pushes: must be dropped
    push_valid_i = 1'b1;
    push_data_i  = 128'hBAD;
    tick();
    push_valid_i = 1'b0;
    chk("t3_extra_push_occ", occ_o, 4);
    rtn_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t3_drain_%0d", i), rtn_data_o, DW'(i));
      tick();
    end
    chk("t3_empty", rtn_valid_o, 0);
    chk("t3_occ0",  occ_o,       0);
    chk("t3_credit_back", credit_o, 1);
    do_reset();
    chk("t3_err_cleared", err_o, 0);

    // 4: steady reserve+push+pop every cycle
    rtn_ready_i = 1'b1;
    rsv_i = 1'b1;
    tick();
    push_valid_i = 1'b1;
    push_data_i  = DW'(100);
    tick();
    for (int i = 1; i <= 20; i++) begin
      push_data_i = DW'(100 + i);
      chk($sformatf("t4_data_%0d", i), rtn_data_o, DW'(100 + i - 1));
      chk($sformatf("t4_occ_%0d", i),  occ_o, 1);
      tick();
    end
    rsv_i = 1'b0;
    push_valid_i = 1'b0;
    chk("t4_last", rtn_data_o, DW'(120));
    tick();
    chk("t4_drained", rtn_valid_o, 0);
    chk("t4_err",     err_o,       0);
    do_reset();

    // 5: push without a reservation is dropped and latches err
    push_valid_i = 1'b1;
    push_data_i  = 128'hDEAD;
    tick();
    push_valid_i = 1'b0;
    chk("t5_occ",   occ_o,       0);
    chk("t5_valid", rtn_valid_o, 0);
    chk("t5_err",   err_o,       1);
    tick();
    tick();
    chk("t5_err_sticky", err_o, 1);
    // reservation in the same cycle does not cover the push
    rsv_i = 1'b1;
    push_valid_i = 1'b1;
    tick();
    rsv_i = 1'b0;
    push_valid_i = 1'b0;
    chk("t5_same_cycle_occ", occ_o, 0);
    chk("t5_credit", credit_o, 1);
    do_reset();

    // 6: reset with entries queued discards them; round-trip still works
    rsv_i = 1'b1;
    tick();
    tick();
    rsv_i = 1'b0;
    push_valid_i = 1'b1;
    push_data_i  = 128'h11;
    tick();
    push_data_i  = 128'h22;
    tick();
    push_valid_i = 1'b0;
    chk("t6_occ2", occ_o, 2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_valid", rtn_valid_o, 0);
    chk("t6_occ",   occ_o,       0);
    chk("t6_credit", credit_o,   1);
    chk("t6_data",  rtn_data_o,  0);
    rsv_i = 1'b1;
    tick();
    rsv_i = 1'b0;
    push_valid_i = 1'b1;
    push_data_i  = 128'h77;
    rtn_ready_i  = 1'b1;
    tick();
    push_valid_i = 1'b0;
    chk("t6_rt_valid", rtn_valid_o, 1);
    chk("t6_rt_data",  rtn_data_o,  128'h77);
    tick();
    chk("t6_rt_done", rtn_valid_o, 0);
    chk("t6_rt_err",  err_o,       0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
